// File: rtl/bky_readback_if.sv
// Signal bundle between the Buckeye readback engine and the JTAG/BPI readout logic.
// The slave modport belongs to the engine; SDOUT/SHCK/SDIN face the shift-register chain.
interface bky_readback_if #(
  parameter int CNT_W = 6
);
  logic             START;
  logic [CNT_W-1:0] NWORDS;
  logic             SDOUT;
  logic             SHCK;
  logic             SDIN;
  logic             BUSY;
  logic             DONE;
  logic             CLR_DONE;
  logic             RD_EN;
  logic [15:0]      RD_DATA;
  logic             EMPTY;
  logic             FULL;
  logic [CNT_W-1:0] WORD_CNT;
  logic             OVFL;

  modport master (
    output START, NWORDS, SDOUT, CLR_DONE, RD_EN,
    input  SHCK, SDIN, BUSY, DONE, RD_DATA, EMPTY, FULL, WORD_CNT, OVFL
  );

  modport slave (
    input  START, NWORDS, SDOUT, CLR_DONE, RD_EN,
    output SHCK, SDIN, BUSY, DONE, RD_DATA, EMPTY, FULL, WORD_CNT, OVFL
  );
endinterface

// File: rtl/bky_readback.sv
// Buckeye chain readback: generates SHCK, deserialises SDOUT LSB-first into 16-bit words, FWFT FIFO.
// Optional macro BKY_RB_RECIRC_EN: SDIN recirculates the last sampled bit (non-destructive readback).
module bky_readback #(
  parameter int CLK_DIV    = 40,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 6
) (
  input logic            CLK40,
  input logic            RST_N,
  bky_readback_if.slave  bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] HALF    = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE_ST} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg;
  logic [3:0]         bit_cnt_reg;
  logic [15:0]        sreg_reg;
  logic               shck_reg;
  logic [CNT_W-1:0]   nwords_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic               done_reg;
  logic               ovfl_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [15:0]        mem [FIFO_DEPTH];

  logic accept, active, write_word, set_done, busy;
  logic sample, last_word, empty, full, pop, push, drop;

  assign sample    = (state_reg == SHIFT) && (div_reg == HALF);
  assign last_word = (word_cnt_reg + CNT_W'(1)) == nwords_reg;
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop       = bus.RD_EN && !empty;
  // A full FIFO still accepts the word when the same cycle pops the head.
  assign push      = write_word && (!full || pop);
  assign drop      = write_word && !push;

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.START) state_next = (bus.NWORDS == '0) ? DONE_ST : SHIFT;
      SHIFT:   if (sample && bit_cnt_reg == 4'd15) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE_ST : SHIFT;
      DONE_ST: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state_reg == IDLE) && bus.START;
    active     = (state_reg == SHIFT) || (state_reg == WRITE);
    write_word = (state_reg == WRITE);
    set_done   = (state_reg == DONE_ST);
    busy       = (state_reg != IDLE);
  end

  // The divider keeps running through WRITE so SHCK stays periodic across word boundaries.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      div_reg      <= '0;
      bit_cnt_reg  <= '0;
      sreg_reg     <= '0;
      shck_reg     <= 1'b0;
      nwords_reg   <= '0;
      word_cnt_reg <= '0;
      done_reg     <= 1'b0;
      ovfl_reg     <= 1'b0;
    end else begin
      if (accept)      div_reg <= '0;
      else if (active) div_reg <= (div_reg == DIV_MAX) ? '0 : div_reg + DIV_W'(1);

      if (accept || write_word) bit_cnt_reg <= '0;
      else if (sample)          bit_cnt_reg <= bit_cnt_reg + 4'd1;

      if (sample) sreg_reg <= {bus.SDOUT, sreg_reg[15:1]};

      shck_reg <= active && (div_reg >= HALF);

      if (accept) nwords_reg <= bus.NWORDS;

      if (accept)          word_cnt_reg <= '0;
      else if (write_word) word_cnt_reg <= word_cnt_reg + CNT_W'(1);

      if (accept)    ovfl_reg <= 1'b0;
      else if (drop) ovfl_reg <= 1'b1;

      if (set_done)                     done_reg <= 1'b1;
      else if (accept || bus.CLR_DONE)  done_reg <= 1'b0;
    end
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge CLK40) begin
    if (push) mem[wr_ptr_reg] <= sreg_reg;
  end

`ifdef BKY_RB_RECIRC_EN
  logic sdin_reg, sampled_reg;
  // sampled_reg blocks the divider's first zero of a run from pushing a stale bit.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      sdin_reg    <= 1'b0;
      sampled_reg <= 1'b0;
    end else begin
      if (accept)      sampled_reg <= 1'b0;
      else if (sample) sampled_reg <= 1'b1;
      if (active && div_reg == '0 && sampled_reg) sdin_reg <= sreg_reg[15];
    end
  end
  assign bus.SDIN = sdin_reg;
`else
  assign bus.SDIN = 1'b0;
`endif

  assign bus.SHCK     = shck_reg;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done_reg;
  assign bus.OVFL     = ovfl_reg;
  assign bus.WORD_CNT = word_cnt_reg;
  assign bus.EMPTY    = empty;
  assign bus.FULL     = full;
  assign bus.RD_DATA  = empty ? 16'h0000 : mem[rd_ptr_reg];
endmodule

// File: tb/tb_bky_readback.sv
// Directed bench for bky_readback: table-driven readback runs plus hand-written corner sequences.
module tb_bky_readback;
  localparam int CLK_DIV = 40, FIFO_DEPTH = 32, CNT_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bky_readback_if #(.CNT_W(CNT_W)) bus();

  bky_readback #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .CLK40(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Chain model: bit k of the stream is presented until the k-th SHCK rise, then advances.
  int          rise_cnt = 0;
  int          sd_base  = 0;
  int          sd_idx;
  logic [15:0] sd_words [0:63];
  always @(posedge bus.SHCK) begin
    #1;
    rise_cnt = rise_cnt + 1;
  end
  assign sd_idx    = rise_cnt - sd_base;
  assign bus.SDOUT = (sd_idx >= 0 && sd_idx < 1024) ? sd_words[sd_idx[9:4]][sd_idx[3:0]] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef BKY_RB_RECIRC_EN
  int rk;
  always @(negedge bus.SHCK) begin
    #2;
    if (bus.BUSY) begin
      rk = rise_cnt - sd_base - 1;
      chk("sdin_recirc", {31'd0, bus.SDIN}, {31'd0, sd_words[rk[9:4]][rk[3:0]]});
    end
  end
`else
  int sdin_bad = 0;
  always @(negedge clk) if (bus.SDIN !== 1'b0) sdin_bad++;
`endif

  task automatic start_run(input int n);
    @(negedge clk);
    bus.NWORDS = n[CNT_W-1:0];
    bus.START  = 1'b1;
    @(negedge clk);
    bus.START  = 1'b0;
  endtask

  // Counts cycles after the START edge until BUSY drops; also records the first SHCK rise.
  task automatic measure(input int budget, input string name, output int first, output int cyc);
    first = 0;
    cyc   = 0;
    while (bus.BUSY && cyc < budget) begin
      cyc++;
      @(negedge clk);
      if (first == 0 && bus.SHCK) first = cyc;
    end
    if (bus.BUSY) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, cyc);
    end
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    chk(name, {16'd0, bus.RD_DATA}, {16'd0, exp});
    bus.RD_EN = 1'b1;
    @(negedge clk);
    bus.RD_EN = 1'b0;
  endtask

  typedef struct {
    int              n;
    logic [2:0][15:0] w;
    int              exp_first;
    int              exp_cycles;
    int              exp_rises;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int first, cyc, r0;
    for (int i = 0; i < 64; i++) sd_words[i] = 16'h0000;
    bus.START = 1'b0; bus.NWORDS = '0; bus.CLR_DONE = 1'b0; bus.RD_EN = 1'b0;

    // cycles = 40*16*n - 17 : last sample at edge 21+40*(16n-1), then WRITE and DONE_ST
    vecs[0] = '{n: 1, w: {16'h0000, 16'h0000, 16'hA5C3}, exp_first: 21, exp_cycles: 623,  exp_rises: 16};
    vecs[1] = '{n: 3, w: {16'h0001, 16'hFFFF, 16'h1234}, exp_first: 21, exp_cycles: 1903, exp_rises: 48};
    vecs[2] = '{n: 2, w: {16'h0000, 16'h8001, 16'h0000}, exp_first: 21, exp_cycles: 1263, exp_rises: 32};

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_shck",  {31'd0, bus.SHCK},  0);
    chk("rst_busy",  {31'd0, bus.BUSY},  0);
    chk("rst_done",  {31'd0, bus.DONE},  0);
    chk("rst_empty", {31'd0, bus.EMPTY}, 1);
    chk("rst_full",  {31'd0, bus.FULL},  0);
    chk("rst_ovfl",  {31'd0, bus.OVFL},  0);
    chk("rst_wcnt",  {26'd0, bus.WORD_CNT}, 0);
    chk("rst_rdata", {16'd0, bus.RD_DATA},  0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_rises", rise_cnt, 0);
    chk("idle_busy",  {31'd0, bus.BUSY}, 0);
    $display("reset/idle: rises=%0d empty=%0b", rise_cnt, bus.EMPTY);

    // Table-driven runs
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 3; j++) sd_words[j] = vecs[v].w[j];
      sd_base = rise_cnt;
      start_run(vecs[v].n);
      measure(vecs[v].n * 16 * CLK_DIV + 100, "run", first, cyc);
      chk("first_rise",  first, vecs[v].exp_first);
      chk("run_cycles",  cyc,   vecs[v].exp_cycles);
      chk("run_rises",   rise_cnt - sd_base, vecs[v].exp_rises);
      chk("run_wcnt",    {26'd0, bus.WORD_CNT}, vecs[v].n);
      chk("run_done",    {31'd0, bus.DONE}, 1);
      chk("run_ovfl",    {31'd0, bus.OVFL}, 0);
      $display("run %0d: nwords=%0d cycles=%0d first_rise=%0d word_cnt=%0d", v, vecs[v].n, cyc, first, bus.WORD_CNT);
      for (int j = 0; j < vecs[v].n; j++) pop_check("rd_data", vecs[v].w[j]);
      chk("drain_empty", {31'd0, bus.EMPTY}, 1);
      bus.RD_EN = 1'b1;
      @(negedge clk);
      bus.RD_EN = 1'b0;
      chk("underflow_empty", {31'd0, bus.EMPTY}, 1);
      chk("underflow_rdata", {16'd0, bus.RD_DATA}, 0);
      bus.CLR_DONE = 1'b1;
      @(negedge clk);
      bus.CLR_DONE = 1'b0;
      chk("clr_done", {31'd0, bus.DONE}, 0);
    end

    // NWORDS = 0: straight to DONE without any SHCK
    r0 = rise_cnt;
    start_run(0);
    measure(3, "nw0", first, cyc);
    chk("nw0_fast",  {31'd0, cyc <= 3}, 1);
    chk("nw0_done",  {31'd0, bus.DONE}, 1);
    chk("nw0_rises", rise_cnt - r0, 0);
    $display("nwords=0: cycles=%0d done=%0b", cyc, bus.DONE);

    // START while busy is ignored
    sd_words[0] = 16'hBEEF; sd_words[1] = 16'h0F0F;
    sd_base = rise_cnt;
    start_run(2);
    repeat (100) @(negedge clk);
    start_run(5);
    measure(2 * 16 * CLK_DIV + 100, "busy_start", first, cyc);
    chk("busy_start_wcnt",  {26'd0, bus.WORD_CNT}, 2);
    chk("busy_start_rises", rise_cnt - sd_base, 32);
    pop_check("busy_start_rd0", 16'hBEEF);
    pop_check("busy_start_rd1", 16'h0F0F);
    $display("start-while-busy: word_cnt=%0d rises=%0d", bus.WORD_CNT, rise_cnt - sd_base);

    // Overflow: 33 words into a 32-deep FIFO with no reads
    for (int j = 0; j < 33; j++) sd_words[j] = 16'h0100 + 16'(j);
    sd_base = rise_cnt;
    start_run(33);
    measure(33 * 16 * CLK_DIV + 100, "ovfl", first, cyc);
    chk("ovfl_full",  {31'd0, bus.FULL}, 1);
    chk("ovfl_flag",  {31'd0, bus.OVFL}, 1);
    chk("ovfl_wcnt",  {26'd0, bus.WORD_CNT}, 33);
    chk("ovfl_done",  {31'd0, bus.DONE}, 1);
    $display("overflow: full=%0b ovfl=%0b word_cnt=%0d", bus.FULL, bus.OVFL, bus.WORD_CNT);
    for (int j = 0; j < 32; j++) pop_check("ovfl_rd", 16'h0100 + 16'(j));
    chk("ovfl_drained", {31'd0, bus.EMPTY}, 1);
    chk("ovfl_notfull", {31'd0, bus.FULL}, 0);
    start_run(0);
    measure(3, "ovfl_clr", first, cyc);
    chk("ovfl_cleared", {31'd0, bus.OVFL}, 0);

    // Reset in the middle of a word
    sd_words[0] = 16'hFFFF;
    sd_base = rise_cnt;
    start_run(1);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, bus.BUSY}, 0);
    chk("mid_rst_shck",  {31'd0, bus.SHCK}, 0);
    chk("mid_rst_wcnt",  {26'd0, bus.WORD_CNT}, 0);
    chk("mid_rst_done",  {31'd0, bus.DONE}, 0);
    chk("mid_rst_empty", {31'd0, bus.EMPTY}, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r0 = rise_cnt;
    repeat (700) @(negedge clk);
    chk("post_rst_empty", {31'd0, bus.EMPTY}, 1);
    chk("post_rst_busy",  {31'd0, bus.BUSY}, 0);
    chk("post_rst_rises", rise_cnt - r0, 0);
    $display("mid-word reset: empty=%0b busy=%0b", bus.EMPTY, bus.BUSY);

`ifndef BKY_RB_RECIRC_EN
    chk("sdin_zero", sdin_bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
